// File: rtl/audio_pkg.sv
// Shared constants and the sample-to-I2S word conversion for the audio output path.
package audio_pkg;

   localparam int SAMPLE_WIDTH   = 9;
   localparam int I2S_WORD_WIDTH = 16;
   localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MIDPOINT = 9'd256;

   // Re-centre the unsigned sample around zero and left-justify it in a 16-bit word.
   // The 9-bit difference is already two's complement, so sign extension followed by
   // a shift of 7 is just the 9 result bits placed at the top of the word.
   function automatic logic [I2S_WORD_WIDTH-1:0] sample_to_i2s(
      input logic [SAMPLE_WIDTH-1:0] sample
   );
      logic [SAMPLE_WIDTH-1:0] centred;
      centred = sample - SAMPLE_MIDPOINT;
      return {centred, {(I2S_WORD_WIDTH - SAMPLE_WIDTH){1'b0}}};
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding audio samples between the producer and the I2S framer.
// Read data is presented combinationally from the head entry; flags come from the
// registered occupancy, so a pop frees space only on the following cycle.
module sample_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 9
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_push,
   input  logic [WIDTH-1:0]              i_data,
   input  logic                          i_pop,
   output logic [WIDTH-1:0]              o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Sample storage; contents are don't-care until written, so no reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: buffers 9-bit unsigned samples and sends each as a 16-bit
// two's-complement word on both channels, 32 BCLK slots per frame, MSB one BCLK
// after the word-select change. A new frame word is fetched on the falling edge
// that enters slot 0 and is shifted out from slot 1 onwards.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int BCLK_HALF  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [SAMPLE_WIDTH-1:0]       i_sample,
   input  logic                          i_sample_valid,
   output logic                          o_sample_ready,
   input  logic                          i_mute,
   output logic                          o_bclk,
   output logic                          o_lrclk,
   output logic                          o_sdata,
   output logic                          o_underrun,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

   logic [DIV_W-1:0]          r_div;
   logic                      r_bclk;
   logic [4:0]                r_slot;
   logic                      r_lrclk;
   logic                      r_sdata;
   logic                      r_underrun;
   logic [31:0]               r_frame;
   logic [SAMPLE_WIDTH-1:0]   r_last;

   logic                      w_tick;
   logic                      w_fall;
   logic                      w_fetch;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_full;
   logic                      w_empty;
   logic [4:0]                w_slot_next;
   logic [4:0]                w_bit_idx;
   logic [SAMPLE_WIDTH-1:0]   w_fifo_data;
   logic [SAMPLE_WIDTH-1:0]   w_next_sample;
   logic [I2S_WORD_WIDTH-1:0] w_word;

   assign w_tick        = (r_div == DIV_LAST);
   assign w_fall        = w_tick & r_bclk;
   assign w_fetch       = w_fall & (r_slot == 5'd31);
   assign w_push        = i_sample_valid & ~w_full;
   assign w_pop         = w_fetch & ~w_empty;
   assign w_slot_next   = r_slot + 5'd1;
   // Slot s carries bit 31-(s-1); the bit for the slot being entered is indexed by
   // the slot being left.
   assign w_bit_idx     = 5'd31 - r_slot;
   // An empty FIFO at fetch time repeats the previous sample.
   assign w_next_sample = w_empty ? r_last : w_fifo_data;
   assign w_word        = i_mute ? '0 : sample_to_i2s(w_next_sample);

   assign o_sample_ready = ~w_full;
   assign o_bclk         = r_bclk;
   assign o_lrclk        = r_lrclk;
   assign o_sdata        = r_sdata;
   assign o_underrun     = r_underrun;

   sample_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (SAMPLE_WIDTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (i_sample),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_fifo_level)
   );

   // Bit clock divider: BCLK toggles each time the divider wraps.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (w_tick) begin
         r_div  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_div  <= r_div + DIV_W'(1);
      end
   end

   // Slot counter, word select and serial data all advance on the BCLK falling edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_slot  <= '0;
         r_lrclk <= 1'b0;
         r_sdata <= 1'b0;
      end else if (w_fall) begin
         r_slot  <= w_slot_next;
         r_lrclk <= w_slot_next[4];
         r_sdata <= r_frame[w_bit_idx];
      end
   end

   // Frame fetch at slot 0: latch the next sample (or repeat) and flag underrun.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_frame    <= '0;
         r_last     <= SAMPLE_MIDPOINT;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_fetch & w_empty;
         if (w_fetch) begin
            r_last  <= w_next_sample;
            r_frame <= {w_word, w_word};
         end
      end
   end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a frame-level reference model predicts FIFO occupancy,
// handshake, clocks, underrun pulses and the word carried by every frame; a separate
// I2S receiver deserialises the pins and compares each frame against the queue.
module tb_audio_i2s_tx;

   localparam int H         = 1;
   localparam int DEPTH     = 4;
   localparam int FRAME_CYC = 64 * H;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [8:0] i_sample = 9'd0;
   logic       i_sample_valid = 1'b0;
   logic       i_mute = 1'b0;
   logic       o_sample_ready;
   logic       o_bclk;
   logic       o_lrclk;
   logic       o_sdata;
   logic       o_underrun;
   logic [2:0] o_fifo_level;

   int n_checks = 0;
   int n_errors = 0;

   audio_i2s_tx #(.BCLK_HALF(H), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .i_mute         (i_mute),
      .o_bclk         (o_bclk),
      .o_lrclk        (o_lrclk),
      .o_sdata        (o_sdata),
      .o_underrun     (o_underrun),
      .o_fifo_level   (o_fifo_level)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Expected 16-bit word: (sample - 256) * 128 in two's complement, or zero when muted.
   function automatic logic [15:0] ref_word(input int s, input bit mute);
      int v;
      if (mute) return 16'h0000;
      v = (s - 256) * 128;
      return v[15:0];
   endfunction

   // ---------------- reference model (evaluated mid-cycle) ----------------
   int          q[$];
   int          last_s = 256;
   int          cyc = 0;
   bit          exp_under = 1'b0;
   logic [31:0] exp_frames[$];
   int          n_fetch = 0;

   always @(negedge i_clk) begin
      bit          accept;
      logic [15:0] w;
      if (i_rst) begin
         chk("rst_bclk", o_bclk, 0);
         chk("rst_lrclk", o_lrclk, 0);
         chk("rst_sdata", o_sdata, 0);
         chk("rst_underrun", o_underrun, 0);
         chk("rst_level", o_fifo_level, 0);
         chk("rst_ready", o_sample_ready, 1);
         q.delete();
         last_s    = 256;
         cyc       = 0;
         exp_under = 1'b0;
         exp_frames.delete();
         exp_frames.push_back(32'h0);
      end else begin
         chk("level", o_fifo_level, q.size());
         chk("ready", o_sample_ready, (q.size() < DEPTH) ? 1 : 0);
         chk("underrun", o_underrun, exp_under);
         chk("bclk", o_bclk, (cyc / H) % 2);
         chk("lrclk", o_lrclk, (((cyc / (2 * H)) % 32) >= 16) ? 1 : 0);
         // predict the effect of the upcoming rising edge
         cyc++;
         accept    = i_sample_valid && (q.size() < DEPTH);
         exp_under = 1'b0;
         if (cyc % FRAME_CYC == 0) begin
            if (q.size() == 0) exp_under = 1'b1;
            else               last_s = q.pop_front();
            w = ref_word(last_s, i_mute);
            exp_frames.push_back({w, w});
            n_fetch++;
         end
         if (accept) q.push_back(int'(i_sample));
      end
   end

   // ---------------- I2S receiver / frame monitor ----------------
   bit          m_prev_bclk = 1'b0;
   bit          m_prev_lr = 1'b0;
   logic [15:0] m_sh = '0;
   logic [15:0] m_left = '0;
   int          n_frames = 0;

   always @(negedge i_clk) begin
      logic [31:0] exp_f;
      if (i_rst) begin
         m_prev_bclk = 1'b0;
         m_prev_lr   = 1'b0;
         m_sh        = '0;
         m_left      = '0;
      end else begin
         if (o_bclk && !m_prev_bclk) begin
            m_sh = {m_sh[14:0], o_sdata};
            if (o_lrclk != m_prev_lr) begin
               if (o_lrclk) begin
                  m_left = m_sh;
               end else if (exp_frames.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL frame_unexpected: got L=%h R=%h expected no frame at %0t",
                           m_left, m_sh, $time);
               end else begin
                  exp_f = exp_frames.pop_front();
                  chk("frame_left", m_left, exp_f[31:16]);
                  chk("frame_right", m_sh, exp_f[15:0]);
                  n_frames++;
               end
            end
            m_prev_lr = o_lrclk;
         end
         m_prev_bclk = o_bclk;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic push_one(input logic [8:0] s);
      i_sample       = s;
      i_sample_valid = 1'b1;
      step(1);
      i_sample_valid = 1'b0;
   endtask

   initial begin
      int guard;
      step(3);
      i_rst = 1'b0;

      // four silence samples fill the FIFO; first frame is the reset word
      for (int i = 0; i < 4; i++) push_one(9'd256);
      step(5 * FRAME_CYC);

      // full-scale negative then positive
      push_one(9'd0);
      push_one(9'd511);
      step(3 * FRAME_CYC);

      // one sample then starvation: repeated word with underrun pulses
      push_one(9'd300);
      step(4 * FRAME_CYC + 7);

      // hold valid high with random data while the FIFO stays full
      i_sample_valid = 1'b1;
      for (int i = 0; i < 6 * FRAME_CYC; i++) begin
         i_sample = 9'($urandom_range(0, 511));
         step(1);
      end
      i_sample_valid = 1'b0;
      step(5 * FRAME_CYC);

      // mute covering the fetch of a queued 511, then unmuted 511
      push_one(9'd511);
      i_mute = 1'b1;
      step(80);
      i_mute = 1'b0;
      push_one(9'd511);
      step(3 * FRAME_CYC);

      // reset in slot 20 with data queued
      push_one(9'd100);
      push_one(9'd200);
      guard = 0;
      while ((cyc % FRAME_CYC) != 40 * H && guard < 4 * FRAME_CYC) begin
         step(1);
         guard++;
      end
      chk("slot20_sync_in_time", (guard < 4 * FRAME_CYC) ? 1 : 0, 1);
      i_rst = 1'b1;
      #1;
      chk("async_rst_bclk", o_bclk, 0);
      chk("async_rst_lrclk", o_lrclk, 0);
      chk("async_rst_sdata", o_sdata, 0);
      chk("async_rst_level", o_fifo_level, 0);
      chk("async_rst_ready", o_sample_ready, 1);
      step(3);
      i_rst = 1'b0;
      step(3 * FRAME_CYC);

      // random traffic with occasional mute changes
      for (int i = 0; i < 40 * FRAME_CYC; i++) begin
         i_sample_valid = ($urandom_range(0, 40) == 0);
         i_sample       = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 150) == 0) i_mute = ~i_mute;
         step(1);
      end
      i_sample_valid = 1'b0;
      i_mute         = 1'b0;
      step(3 * FRAME_CYC);

      chk("frames_observed", (n_frames >= 70) ? 1 : 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
